// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: rotates an active-low column strobe on each scan tick,
// debounces presses and releases over DEBOUNCE_SCANS samples, reports one pulse per press.
module keypad_scanner #(
    parameter int DEBOUNCE_SCANS = 4,
    parameter int CNT_W          = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       t,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;

    localparam logic [CNT_W-1:0] DB_MAX = CNT_W'(DEBOUNCE_SCANS);
    localparam bit               DB_ONE = (DEBOUNCE_SCANS <= 1);

    logic [1:0]       t_sync;
    logic             t_d;
    logic [3:0]       rows_s1, rows_s;
    logic             scan_en;

    state_t           state;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_inc;
    logic [3:0]       pat;
    logic [1:0]       col_lat;

    // Lowest-numbered low bit; gives row priority and decodes the one-cold column strobe.
    function automatic logic [1:0] low_idx(input logic [3:0] v);
        logic [1:0] idx;
        if (!v[0])      idx = 2'd0;
        else if (!v[1]) idx = 2'd1;
        else if (!v[2]) idx = 2'd2;
        else            idx = 2'd3;
        return idx;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_sync  <= 2'b00;
            t_d     <= 1'b0;
            rows_s1 <= 4'hf;
            rows_s  <= 4'hf;
        end else begin
            t_sync  <= {t_sync[0], t};
            t_d     <= t_sync[1];
            rows_s1 <= rows;
            rows_s  <= rows_s1;
        end
    end

    assign scan_en   = t_sync[1] & ~t_d;
    assign count_inc = count + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SCAN;
            cols      <= 4'b1110;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
            count     <= '0;
            pat       <= 4'hf;
            col_lat   <= 2'd0;
        end else begin
            key_valid <= 1'b0;
            if (scan_en) begin
                case (state)
                    SCAN: begin
                        if (rows_s == 4'hf) begin
                            cols <= {cols[2:0], cols[3]};
                        end else if (DB_ONE) begin
                            key_code  <= {low_idx(rows_s), low_idx(cols)};
                            key_valid <= 1'b1;
                            key_held  <= 1'b1;
                            count     <= '0;
                            state     <= PRESSED;
                        end else begin
                            pat     <= rows_s;
                            col_lat <= low_idx(cols);
                            count   <= CNT_W'(1);
                            state   <= DEBOUNCE;
                        end
                    end
                    DEBOUNCE: begin
                        if (rows_s == pat) begin
                            if (count_inc >= DB_MAX) begin
                                key_code  <= {low_idx(pat), col_lat};
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                                count     <= '0;
                                state     <= PRESSED;
                            end else begin
                                count <= count_inc;
                            end
                        end else begin
                            // Bounce: drop the candidate and move on rather than re-latching.
                            count <= '0;
                            cols  <= {cols[2:0], cols[3]};
                            state <= SCAN;
                        end
                    end
                    PRESSED: begin
                        if (rows_s == 4'hf) begin
                            if (DB_ONE) begin
                                key_held <= 1'b0;
                                count    <= '0;
                                cols     <= {cols[2:0], cols[3]};
                                state    <= SCAN;
                            end else begin
                                count <= CNT_W'(1);
                                state <= RELEASE;
                            end
                        end
                    end
                    RELEASE: begin
                        if (rows_s == 4'hf) begin
                            if (count_inc >= DB_MAX) begin
                                key_held <= 1'b0;
                                count    <= '0;
                                cols     <= {cols[2:0], cols[3]};
                                state    <= SCAN;
                            end else begin
                                count <= count_inc;
                            end
                        end else begin
                            count <= '0;
                            state <= PRESSED;
                        end
                    end
                    default: state <= SCAN;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a physical keypad model drives rows from the column strobe,
// directed per-tick vectors plus randomized press episodes against a sample-history model.
module tb_keypad_scanner;

    localparam int DB = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        t;
    logic [15:0] pressed;
    logic [3:0]  rows;
    logic [3:0]  cols;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;

    int checks = 0;
    int errors = 0;
    int vpulses = 0, vrun = 0, vrun_max = 0;
    int tick_pulses;

    always #5 clk = ~clk;

    // Key index r*4+c shorts row r to column c; a driven (low) column pulls that row low.
    function automatic logic [3:0] kp(input logic [15:0] m, input logic [3:0] c);
        logic [3:0] r;
        r = 4'hf;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                if (m[i*4+j] && !c[j]) r[i] = 1'b0;
        return r;
    endfunction

    assign rows = kp(pressed, cols);

    keypad_scanner #(.DEBOUNCE_SCANS(DB), .CNT_W(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .t         (t),
        .rows      (rows),
        .cols      (cols),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    always @(negedge clk) begin
        if (key_valid === 1'b1) begin
            vpulses++;
            vrun++;
            if (vrun > vrun_max) vrun_max = vrun;
        end else begin
            vrun = 0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_tick(input logic [15:0] m);
        int v0;
        pressed = m;
        v0 = vpulses;
        t = 1'b1;
        repeat (4) @(negedge clk);
        t = 1'b0;
        repeat (4) @(negedge clk);
        tick_pulses = vpulses - v0;
    endtask

    // Reference: tracks the strobed column and the run of samples taken at it.
    int         m_col;
    bit         m_held;
    logic [3:0] m_code;
    int         m_rel;
    int         m_pulses;
    logic [3:0] m_hist[$];

    function automatic int lowest_low(input logic [3:0] s);
        for (int i = 0; i < 4; i++) if (!s[i]) return i;
        return 0;
    endfunction

    task automatic model_tick(input logic [15:0] m);
        logic [3:0] s;
        s = kp(m, 4'hf & ~(4'b1 << m_col));
        m_pulses = 0;
        if (m_held) begin
            if (s == 4'hf) begin
                m_rel++;
                if (m_rel == DB) begin
                    m_held = 0;
                    m_rel  = 0;
                    m_col  = (m_col + 1) % 4;
                end
            end else begin
                m_rel = 0;
            end
        end else if (m_hist.size() == 0) begin
            if (s == 4'hf) m_col = (m_col + 1) % 4;
            else           m_hist.push_back(s);
        end else if (s == m_hist[0]) begin
            m_hist.push_back(s);
            if (m_hist.size() == DB) begin
                m_code   = 4'(lowest_low(s) * 4 + m_col);
                m_held   = 1;
                m_pulses = 1;
                m_hist.delete();
            end
        end else begin
            m_hist.delete();
            m_col = (m_col + 1) % 4;
        end
    endtask

    typedef struct {
        logic [15:0] mask;
        logic [3:0]  cols;
        logic        held;
        logic [3:0]  code;
        int          pulses;
    } vec_t;

    vec_t vt[$];

    initial begin
        int v0;
        int ep_len;
        logic [15:0] ep_key;
        logic [15:0] m;

        // idle rotation
        vt.push_back('{16'h0000, 4'b1101, 1'b0, 4'd0, 0});
        vt.push_back('{16'h0000, 4'b1011, 1'b0, 4'd0, 0});
        vt.push_back('{16'h0000, 4'b0111, 1'b0, 4'd0, 0});
        vt.push_back('{16'h0000, 4'b1110, 1'b0, 4'd0, 0});
        vt.push_back('{16'h0000, 4'b1101, 1'b0, 4'd0, 0});
        vt.push_back('{16'h0000, 4'b1011, 1'b0, 4'd0, 0});
        // row 2 / col 2 held six ticks
        vt.push_back('{16'h0400, 4'b1011, 1'b0, 4'd0, 0});
        vt.push_back('{16'h0400, 4'b1011, 1'b0, 4'd0, 0});
        vt.push_back('{16'h0400, 4'b1011, 1'b0, 4'd0, 0});
        vt.push_back('{16'h0400, 4'b1011, 1'b1, 4'd10, 1});
        vt.push_back('{16'h0400, 4'b1011, 1'b1, 4'd10, 0});
        vt.push_back('{16'h0400, 4'b1011, 1'b1, 4'd10, 0});
        // release with a glitch on the second release tick
        vt.push_back('{16'h0000, 4'b1011, 1'b1, 4'd10, 0});
        vt.push_back('{16'h0400, 4'b1011, 1'b1, 4'd10, 0});
        vt.push_back('{16'h0000, 4'b1011, 1'b1, 4'd10, 0});
        vt.push_back('{16'h0000, 4'b1011, 1'b1, 4'd10, 0});
        vt.push_back('{16'h0000, 4'b1011, 1'b1, 4'd10, 0});
        vt.push_back('{16'h0000, 4'b0111, 1'b0, 4'd10, 0});
        // back round to col 2, then a bounce
        vt.push_back('{16'h0000, 4'b1110, 1'b0, 4'd10, 0});
        vt.push_back('{16'h0000, 4'b1101, 1'b0, 4'd10, 0});
        vt.push_back('{16'h0000, 4'b1011, 1'b0, 4'd10, 0});
        vt.push_back('{16'h0400, 4'b1011, 1'b0, 4'd10, 0});
        vt.push_back('{16'h0000, 4'b0111, 1'b0, 4'd10, 0});
        vt.push_back('{16'h0000, 4'b1110, 1'b0, 4'd10, 0});
        // rows 0 and 3 together on col 1: row 0 wins
        vt.push_back('{16'h2002, 4'b1101, 1'b0, 4'd10, 0});
        vt.push_back('{16'h2002, 4'b1101, 1'b0, 4'd10, 0});
        vt.push_back('{16'h2002, 4'b1101, 1'b0, 4'd10, 0});
        vt.push_back('{16'h2002, 4'b1101, 1'b0, 4'd10, 0});
        vt.push_back('{16'h2002, 4'b1101, 1'b1, 4'd1, 1});
        vt.push_back('{16'h0000, 4'b1101, 1'b1, 4'd1, 0});
        vt.push_back('{16'h0000, 4'b1101, 1'b1, 4'd1, 0});
        vt.push_back('{16'h0000, 4'b1101, 1'b1, 4'd1, 0});
        vt.push_back('{16'h0000, 4'b1011, 1'b0, 4'd1, 0});
        // debounce to count 3, interrupted by reset below
        vt.push_back('{16'h0400, 4'b1011, 1'b0, 4'd1, 0});
        vt.push_back('{16'h0400, 4'b1011, 1'b0, 4'd1, 0});
        vt.push_back('{16'h0400, 4'b1011, 1'b0, 4'd1, 0});

        rst_n = 1'b0;
        t = 1'b0;
        pressed = 16'h0;
        repeat (3) @(negedge clk);
        chk("reset cols", 32'(cols), 32'(4'b1110));
        chk("reset code", 32'(key_code), 32'd0);
        chk("reset valid", 32'(key_valid), 32'd0);
        chk("reset held", 32'(key_held), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vt[i]) begin
            do_tick(vt[i].mask);
            chk($sformatf("vec%0d cols", i), 32'(cols), 32'(vt[i].cols));
            chk($sformatf("vec%0d held", i), 32'(key_held), 32'(vt[i].held));
            chk($sformatf("vec%0d code", i), 32'(key_code), 32'(vt[i].code));
            chk($sformatf("vec%0d pulses", i), 32'(tick_pulses), 32'(vt[i].pulses));
        end

        // asynchronous reset mid-debounce, key still down
        rst_n = 1'b0;
        #1;
        chk("async cols", 32'(cols), 32'(4'b1110));
        chk("async code", 32'(key_code), 32'd0);
        chk("async held", 32'(key_held), 32'd0);
        chk("async valid", 32'(key_valid), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        v0 = vpulses;
        repeat (10) @(negedge clk);
        chk("idle after reset cols", 32'(cols), 32'(4'b1110));
        t = 1'b1;
        repeat (2) @(negedge clk);
        chk("pre first scan cols", 32'(cols), 32'(4'b1110));
        @(negedge clk);
        chk("first scan cols", 32'(cols), 32'(4'b1101));
        @(negedge clk);
        t = 1'b0;
        repeat (4) @(negedge clk);
        for (int k = 0; k < 4; k++) do_tick(16'h0400);
        chk("post reset no pulse", 32'(vpulses - v0), 32'd0);
        chk("post reset held", 32'(key_held), 32'd0);
        do_tick(16'h0400);
        chk("redebounce pulse", 32'(tick_pulses), 32'd1);
        chk("redebounce code", 32'(key_code), 32'd10);
        chk("redebounce held", 32'(key_held), 32'd1);

        // randomized press episodes
        pressed = 16'h0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        m_col = 0; m_held = 0; m_code = 4'd0; m_rel = 0; m_hist.delete();
        ep_len = 0;
        ep_key = 16'h0;
        for (int n = 0; n < 300; n++) begin
            if (ep_len == 0) begin
                if ($urandom_range(0, 3) == 0) ep_key = 16'h0;
                else                           ep_key = 16'(1) << $urandom_range(0, 15);
                ep_len = $urandom_range(1, 12);
            end
            ep_len--;
            m = ep_key;
            if (m != 16'h0 && $urandom_range(0, 9) == 0) m = 16'h0;
            if ($urandom_range(0, 11) == 0) m = m | (16'(1) << $urandom_range(0, 15));
            model_tick(m);
            do_tick(m);
            chk($sformatf("rnd%0d cols", n), 32'(cols), 32'(4'hf & ~(4'b1 << m_col)));
            chk($sformatf("rnd%0d held", n), 32'(key_held), 32'(m_held));
            chk($sformatf("rnd%0d code", n), 32'(key_code), 32'(m_code));
            chk($sformatf("rnd%0d pulses", n), 32'(tick_pulses), 32'(m_pulses));
        end

        chk("valid width", 32'(vrun_max), 32'd1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
